// File: rtl/cpu_step_controller.sv
// Purpose: glitch-free CPU clock generator with cycle/instruction stepping, divided free-run and PC breakpoint.
// Latency: cpuClk rises on the clk edge that first samples a step edge (or the edge after IDLE sees an auto mode).
// Backpressure: none; step edges arriving during a pulse are dropped, and optional counters need CPU_STEP_COUNTERS_EN.
module cpu_step_controller #(
    parameter int unsigned HALF_PERIOD = 4,
    parameter logic [3:0]  FETCH_STATE = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stepBtn,
    input  logic [1:0]  mode,
    input  logic [31:0] breakAddr,
    input  logic [31:0] pcOut,
    input  logic [3:0]  state,
    output logic        cpuClk,
    output logic        running,
    output logic        halted,
    output logic [31:0] cycleCount,
    output logic [31:0] instrCount
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2,
        S_HALT = 2'd3
    } fsm_t;

    localparam int unsigned CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CW-1:0] PH_LAST = CW'(HALF_PERIOD - 1);

    fsm_t          fsm_q, fsm_d;
    logic [CW-1:0] phase_q, phase_d;
    logic [1:0]    run_mode_q, run_mode_d;
    logic          cpu_clk_q, cpu_clk_d;
    logic          running_q, running_d;
    logic          halted_q, halted_d;
    logic          skip_brk_q, skip_brk_d;
    logic          step_prev_q;

    logic          step_edge;
    logic          phase_last;
    logic          at_fetch;
    logic          go_idle;
    logic          go_halt;

    assign step_edge  = stepBtn & ~step_prev_q;
    assign phase_last = (phase_q == PH_LAST);
    assign at_fetch   = (state == FETCH_STATE);

    // Next-state and next-output logic; every cpuClk change is decided here and registered below.
    always_comb begin
        fsm_d      = fsm_q;
        phase_d    = phase_q;
        run_mode_d = run_mode_q;
        cpu_clk_d  = cpu_clk_q;
        running_d  = running_q;
        halted_d   = halted_q;
        skip_brk_d = skip_brk_q;
        go_idle    = 1'b0;
        go_halt    = 1'b0;

        case (fsm_q)
            S_IDLE: begin
                // Auto modes start at once; manual modes wait for a fresh press.
                if (mode[1] || step_edge) begin
                    fsm_d      = S_HIGH;
                    cpu_clk_d  = 1'b1;
                    running_d  = 1'b1;
                    phase_d    = '0;
                    run_mode_d = mode;
                    skip_brk_d = 1'b0;
                end
            end

            S_HIGH: begin
                if (phase_last) begin
                    fsm_d     = S_LOW;
                    cpu_clk_d = 1'b0;
                    phase_d   = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end

            S_LOW: begin
                if (phase_last) begin
                    phase_d = '0;
                    case (run_mode_q)
                        2'd0:    go_idle = 1'b1;
                        2'd1:    go_idle = at_fetch;
                        default: begin
                            // The cycle stepped out of HALT must not re-trigger on the same PC.
                            if (run_mode_q == 2'd3 && !skip_brk_q && pcOut == breakAddr) begin
                                go_halt = 1'b1;
                            end else begin
                                go_idle = !mode[1];
                            end
                        end
                    endcase

                    skip_brk_d = 1'b0;
                    if (go_halt) begin
                        fsm_d     = S_HALT;
                        running_d = 1'b0;
                        halted_d  = 1'b1;
                    end else if (go_idle) begin
                        fsm_d     = S_IDLE;
                        running_d = 1'b0;
                    end else begin
                        fsm_d     = S_HIGH;
                        cpu_clk_d = 1'b1;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end

            S_HALT: begin
                // Leaving mode 3 takes priority over a simultaneous press.
                if (mode != 2'd3) begin
                    fsm_d    = S_IDLE;
                    halted_d = 1'b0;
                end else if (step_edge) begin
                    fsm_d      = S_HIGH;
                    cpu_clk_d  = 1'b1;
                    running_d  = 1'b1;
                    halted_d   = 1'b0;
                    phase_d    = '0;
                    skip_brk_d = 1'b1;
                end
            end

            default: begin
                fsm_d     = S_IDLE;
                cpu_clk_d = 1'b0;
                running_d = 1'b0;
                halted_d  = 1'b0;
                phase_d   = '0;
            end
        endcase
    end

    // FSM, phase counter and registered outputs; reset drops cpuClk immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q       <= S_IDLE;
            phase_q     <= '0;
            run_mode_q  <= 2'd0;
            cpu_clk_q   <= 1'b0;
            running_q   <= 1'b0;
            halted_q    <= 1'b0;
            skip_brk_q  <= 1'b0;
            step_prev_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            phase_q     <= phase_d;
            run_mode_q  <= run_mode_d;
            cpu_clk_q   <= cpu_clk_d;
            running_q   <= running_d;
            halted_q    <= halted_d;
            skip_brk_q  <= skip_brk_d;
            step_prev_q <= stepBtn;
        end
    end

    assign cpuClk  = cpu_clk_q;
    assign running = running_q;
    assign halted  = halted_q;

`ifdef CPU_STEP_COUNTERS_EN
    logic [31:0] cycle_count_q, cycle_count_d;
    logic [31:0] instr_count_q, instr_count_d;
    logic        cyc_done;

    assign cyc_done = (fsm_q == S_LOW) && phase_last;

    // A cycle counts only when its LOW phase completes; partial cycles cut by reset are lost.
    always_comb begin
        cycle_count_d = cycle_count_q;
        instr_count_d = instr_count_q;
        if (cyc_done) begin
            cycle_count_d = cycle_count_q + 32'd1;
            if (at_fetch) begin
                instr_count_d = instr_count_q + 32'd1;
            end
        end
    end

    // Free-running wrap-around counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_count_q <= 32'd0;
            instr_count_q <= 32'd0;
        end else begin
            cycle_count_q <= cycle_count_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign cycleCount = cycle_count_q;
    assign instrCount = instr_count_q;
`else
    assign cycleCount = 32'd0;
    assign instrCount = 32'd0;
`endif

endmodule

// File: tb/tb_cpu_step_controller.sv
// Bench for cpu_step_controller: predicted per-cycle counter values are queued as stimulus is
// issued and popped by a pulse monitor that also measures each cpuClk high/low phase.
// A small CPU model advances state (0->1->2->0) and PC (+4) on every cpuClk rising edge.
module tb_cpu_step_controller;

    localparam int HP = 4;
`ifdef CPU_STEP_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        stepBtn;
    logic [1:0]  mode;
    logic [31:0] breakAddr;
    logic [31:0] pcOut;
    logic [3:0]  state;
    logic        cpuClk;
    logic        running;
    logic        halted;
    logic [31:0] cycleCount;
    logic [31:0] instrCount;

    typedef struct {
        logic [31:0] cyc;
        logic [31:0] ins;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] exp_cyc;
    logic [31:0] exp_ins;
    logic [31:0] base_c;
    logic [31:0] base_i;
    logic [3:0]  pred_state;

    logic        model_clr;
    logic [3:0]  cpu_state;
    logic [31:0] cpu_pc;

    cpu_step_controller #(
        .HALF_PERIOD (HP),
        .FETCH_STATE (4'd0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stepBtn    (stepBtn),
        .mode       (mode),
        .breakAddr  (breakAddr),
        .pcOut      (pcOut),
        .state      (state),
        .cpuClk     (cpuClk),
        .running    (running),
        .halted     (halted),
        .cycleCount (cycleCount),
        .instrCount (instrCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign state = cpu_state;
    assign pcOut = cpu_pc;

    always @(posedge cpuClk or posedge model_clr) begin
        if (model_clr) begin
            cpu_state <= 4'd0;
            cpu_pc    <= 32'd0;
        end else begin
            cpu_state <= (cpu_state == 4'd2) ? 4'd0 : cpu_state + 4'd1;
            cpu_pc    <= cpu_pc + 32'd4;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Predict the counter values seen after one more completed cpuClk cycle.
    task automatic push_pulse();
        exp_t e;
        pred_state = (pred_state == 4'd2) ? 4'd0 : pred_state + 4'd1;
        exp_cyc    = exp_cyc + 32'd1;
        if (pred_state == 4'd0) exp_ins = exp_ins + 32'd1;
        e.cyc = CNT_EN ? exp_cyc : 32'd0;
        e.ins = CNT_EN ? exp_ins : 32'd0;
        exp_q.push_back(e);
    endtask

    task automatic clr_model();
        model_clr = 1'b1;
        #1 model_clr = 1'b0;
        pred_state = 4'd0;
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse monitor: measures phases and, one clk after each LOW phase ends, checks the counters.
    int hi_n = 0;
    int lo_n = 0;
    bit in_pulse = 1'b0;
    bit prev_clk = 1'b0;
    bit cmp_pend = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            hi_n     = 0;
            lo_n     = 0;
            in_pulse = 1'b0;
            prev_clk = 1'b0;
            cmp_pend = 1'b0;
        end else begin
            if (cmp_pend) begin
                cmp_pend = 1'b0;
                chk("pulse_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("cycle_count", cycleCount, mon_e.cyc);
                    chk("instr_count", instrCount, mon_e.ins);
                end
            end
            if (cpuClk) begin
                if (!prev_clk) begin
                    if (in_pulse) chk("lo_len", lo_n, HP);
                    in_pulse = 1'b1;
                    hi_n     = 1;
                    lo_n     = 0;
                end else begin
                    hi_n++;
                end
            end else if (in_pulse) begin
                lo_n++;
                if (lo_n == 1) chk("hi_len", hi_n, HP);
                if (lo_n == HP) begin
                    cmp_pend = 1'b1;
                    in_pulse = 1'b0;
                end
            end
            prev_clk = cpuClk;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b0;
        stepBtn    = 1'b1;
        mode       = 2'd2;
        breakAddr  = 32'd0;
        model_clr  = 1'b0;
        pred_state = 4'd0;
        exp_cyc    = 32'd0;
        exp_ins    = 32'd0;
        clr_model();

        // Reset holds everything quiet even with a pressed button and auto mode selected.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_cpuclk", {31'd0, cpuClk}, 32'd0);
            chk("rst_running", {31'd0, running}, 32'd0);
            chk("rst_halted", {31'd0, halted}, 32'd0);
            chk("rst_cycles", cycleCount, 32'd0);
            chk("rst_instrs", instrCount, 32'd0);
        end
        stepBtn = 1'b0;
        mode    = 2'd0;
        @(negedge clk);
        rst = 1'b1;
        wait_clks(3);
        chk("idle_cpuclk", {31'd0, cpuClk}, 32'd0);

        // Manual cycle: three short presses, then one 100-clk hold.
        for (int i = 0; i < 3; i++) begin
            push_pulse();
            @(negedge clk);
            stepBtn = 1'b1;
            @(negedge clk);
            chk("step_latency", {31'd0, cpuClk}, 32'd1);
            wait_clks(1);
            stepBtn = 1'b0;
            wait_clks(2 * HP + 4);
        end
        push_pulse();
        @(negedge clk);
        stepBtn = 1'b1;
        wait_clks(100);
        stepBtn = 1'b0;
        wait_clks(12);
        chk("manual_cycles", cycleCount, CNT_EN ? 32'd4 : 32'd0);
        chk("manual_q_empty", exp_q.size(), 32'd0);

        // Instruction step: one press runs 0->1->2->0 and stops.
        clr_model();
        mode   = 2'd1;
        base_c = exp_cyc;
        base_i = exp_ins;
        repeat (3) push_pulse();
        @(negedge clk);
        stepBtn = 1'b1;
        wait_clks(2);
        stepBtn = 1'b0;
        wait_clks(3 * 2 * HP + 6);
        chk("instr_running", {31'd0, running}, 32'd0);
        chk("instr_icount", instrCount, CNT_EN ? base_i + 32'd1 : 32'd0);
        chk("instr_ccount", cycleCount, CNT_EN ? base_c + 32'd3 : 32'd0);
        chk("instr_q_empty", exp_q.size(), 32'd0);

        // Breakpoint at 0xC: halts after the third cycle.
        clr_model();
        breakAddr = 32'h0000_000C;
        base_c    = exp_cyc;
        repeat (3) push_pulse();
        @(negedge clk);
        mode = 2'd3;
        wait_clks(3 * 2 * HP + 6);
        chk("brk_halted", {31'd0, halted}, 32'd1);
        chk("brk_running", {31'd0, running}, 32'd0);
        chk("brk_cpuclk", {31'd0, cpuClk}, 32'd0);
        chk("brk_cycles", cycleCount, CNT_EN ? base_c + 32'd3 : 32'd0);
        wait_clks(20);
        chk("brk_still_halted", {31'd0, halted}, 32'd1);
        chk("brk_q_empty", exp_q.size(), 32'd0);

        // Step past the breakpoint, let auto run resume for two cycles, then leave mode 3.
        repeat (3) push_pulse();
        @(negedge clk);
        stepBtn = 1'b1;
        @(negedge clk);
        chk("brkstep_cpuclk", {31'd0, cpuClk}, 32'd1);
        chk("brkstep_halted", {31'd0, halted}, 32'd0);
        chk("brkstep_running", {31'd0, running}, 32'd1);
        stepBtn = 1'b0;
        wait_clks(7);
        chk("brkstep_pc", pcOut, 32'h0000_0010);
        chk("brkstep_low", {31'd0, cpuClk}, 32'd0);
        wait_clks(1);
        chk("brk_resume", {31'd0, cpuClk}, 32'd1);
        wait_clks(11);
        mode = 2'd0;
        wait_clks(14);
        chk("brkend_running", {31'd0, running}, 32'd0);
        chk("brkend_halted", {31'd0, halted}, 32'd0);
        chk("brkend_q_empty", exp_q.size(), 32'd0);

        // Mode change one clk into HIGH must not shorten the cycle, then stop.
        push_pulse();
        @(negedge clk);
        mode = 2'd2;
        @(negedge clk);
        chk("modechg_rise", {31'd0, cpuClk}, 32'd1);
        mode = 2'd0;
        wait_clks(20);
        chk("modechg_running", {31'd0, running}, 32'd0);
        chk("modechg_cpuclk", {31'd0, cpuClk}, 32'd0);
        chk("modechg_q_empty", exp_q.size(), 32'd0);

        // Asynchronous reset two clk into HIGH.
        base_c = CNT_EN ? exp_cyc : 32'd0;
        @(negedge clk);
        mode = 2'd2;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("arst_pre_high", {31'd0, cpuClk}, 32'd1);
        chk("arst_pre_cycles", cycleCount, base_c);
        rst = 1'b0;
        #1;
        chk("arst_cpuclk", {31'd0, cpuClk}, 32'd0);
        chk("arst_cycles", cycleCount, 32'd0);
        mode    = 2'd0;
        exp_cyc = 32'd0;
        exp_ins = 32'd0;
        wait_clks(2);
        rst = 1'b1;
        wait_clks(5);
        chk("post_rst_cpuclk", {31'd0, cpuClk}, 32'd0);
        chk("post_rst_running", {31'd0, running}, 32'd0);
        chk("post_rst_instrs", instrCount, 32'd0);
        chk("final_q_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
